led_chaser: RTL and testbench

- Downstream consumer of the frequency divider's 4-bit slow count.
- Every value change on the count is one step event. Each step event moves a one-hot light along an LED bank in the selected pattern: shift left, shift right, ping-pong, or hold.
- Drives the board LEDs directly and exposes step and wrap pulses for other stages.

---
 rtl/led_chaser.sv | 129 ++++++++++++
 tb/tb_led_chaser.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser.sv
// One-hot LED chaser that advances once for every value change on the divider's slow count.
// Define LED_CHASER_STEP_CNT_EN to add a saturating 16-bit step_cnt output.
module led_chaser #(
  parameter int LED_W     = 8,
  parameter int START_POS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       count_in,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             dir,
  output logic             step,
`ifdef LED_CHASER_STEP_CNT_EN
  output logic [15:0]      step_cnt,
`endif
  output logic             wrap
);

  localparam int POS_W = $clog2(LED_W);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LED_W - 1);
  localparam logic [POS_W-1:0] POS_PEN   = POS_W'(LED_W - 2);
  localparam logic [POS_W-1:0] POS_START = POS_W'(START_POS);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_LEFT   = 2'b01;
  localparam logic [1:0] MODE_RIGHT  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  logic [3:0]       count_prev;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_nxt;
  logic             dir_nxt;
  logic             step_nxt;
  logic             wrap_nxt;
  logic             evt;

  // count_prev also loads during reset so release never produces a phantom event
  always_ff @(posedge clk) begin
    count_prev <= count_in;
  end

  assign evt = (count_in != count_prev) & ~rst;

  always_comb begin
    pos_nxt  = pos;
    dir_nxt  = dir;
    step_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (evt && !pause && mode != MODE_HOLD) begin
      step_nxt = 1'b1;
      case (mode)
        MODE_LEFT: begin
          dir_nxt = 1'b0;
          if (pos == POS_LAST) begin
            pos_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            pos_nxt = pos + 1'b1;
          end
        end
        MODE_RIGHT: begin
          dir_nxt = 1'b1;
          if (pos == '0) begin
            pos_nxt  = POS_LAST;
            wrap_nxt = 1'b1;
          end else begin
            pos_nxt = pos - 1'b1;
          end
        end
        MODE_BOUNCE: begin
          // bounce keeps whatever direction the previous mode left behind
          if (!dir) begin
            if (pos == POS_LAST) begin
              pos_nxt  = POS_PEN;
              dir_nxt  = 1'b1;
              wrap_nxt = 1'b1;
            end else begin
              pos_nxt = pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              pos_nxt  = POS_W'(1);
              dir_nxt  = 1'b0;
              wrap_nxt = 1'b1;
            end else begin
              pos_nxt = pos - 1'b1;
            end
          end
        end
        default: begin
          step_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos  <= POS_START;
      dir  <= 1'b0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      pos  <= pos_nxt;
      dir  <= dir_nxt;
      step <= step_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign led = LED_W'(1) << pos;

`ifdef LED_CHASER_STEP_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (step_nxt) begin
      step_cnt <= sat_inc(step_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: directed scenarios plus randomized traffic
// compared against a position/direction reference model.
module tb_led_chaser;
  localparam int LED_W     = 8;
  localparam int START_POS = 0;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       count_in;
  logic [1:0]       mode;
  logic             pause;
  logic [LED_W-1:0] led;
  logic             dir;
  logic             step;
  logic             wrap;
`ifdef LED_CHASER_STEP_CNT_EN
  logic [15:0]      step_cnt;
  int               m_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int m_pos, m_dir, m_step, m_wrap;
  int m_prev;

  always #5 clk = ~clk;

  led_chaser #(.LED_W(LED_W), .START_POS(START_POS)) dut (
    .clk(clk),
    .rst(rst),
    .count_in(count_in),
    .mode(mode),
    .pause(pause),
    .led(led),
    .dir(dir),
    .step(step),
`ifdef LED_CHASER_STEP_CNT_EN
    .step_cnt(step_cnt),
`endif
    .wrap(wrap)
  );

  // Reference model: advances an integer position on each clock edge, then samples after it.
  task automatic tick();
    if (rst) begin
      m_pos = START_POS; m_dir = 0; m_step = 0; m_wrap = 0;
`ifdef LED_CHASER_STEP_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      m_step = 0; m_wrap = 0;
      if (int'(count_in) != m_prev && !pause && mode != 2'b00) begin
        m_step = 1;
        if (mode == 2'b01) begin
          m_dir = 0; m_wrap = (m_pos == LED_W - 1); m_pos = (m_pos + 1) % LED_W;
        end else if (mode == 2'b10) begin
          m_dir = 1; m_wrap = (m_pos == 0); m_pos = (m_pos + LED_W - 1) % LED_W;
        end else if (m_dir == 0) begin
          if (m_pos == LED_W - 1) begin m_pos = LED_W - 2; m_dir = 1; m_wrap = 1; end
          else m_pos = m_pos + 1;
        end else begin
          if (m_pos == 0) begin m_pos = 1; m_dir = 0; m_wrap = 1; end
          else m_pos = m_pos - 1;
        end
`ifdef LED_CHASER_STEP_CNT_EN
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      end
    end
    m_prev = int'(count_in);
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    count_in = count_in + 4'd1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; count_in = 4'd5; mode = 2'b01; pause = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      checks++;
      if (led !== 8'h01 || dir !== 1'b0 || step !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: led=%h dir=%b step=%b wrap=%b, expected led=01 dir=0 step=0 wrap=0",
                 i, led, dir, step, wrap);
      end
    end
`ifdef LED_CHASER_STEP_CNT_EN
    checks++;
    if (step_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_step_cnt: got %0d expected 0", step_cnt);
    end
`endif
  endtask

  task automatic test_left();
    logic [7:0] exp;
    mode = 2'b00; count_in = 4'd0; tick();
    mode = 2'b01;
    for (int v = 1; v <= 8; v++) begin
      count_in = 4'(v);
      tick();
      exp = 8'h01 << (v % 8);
      checks++;
      if (led !== exp || step !== 1'b1 || wrap !== (v == 8) || dir !== 1'b0) begin
        errors++;
        $display("FAIL left_move[%0d]: led=%h step=%b wrap=%b dir=%b, expected led=%h step=1 wrap=%b dir=0",
                 v, led, step, wrap, dir, exp, (v == 8));
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        checks++;
        if (led !== exp || step !== 1'b0 || wrap !== 1'b0) begin
          errors++;
          $display("FAIL left_idle[%0d.%0d]: led=%h step=%b wrap=%b, expected led=%h step=0 wrap=0",
                   v, k, led, step, wrap, exp);
        end
      end
    end
  endtask

  task automatic test_right();
    mode = 2'b10;
    bump();
    checks++;
    if (led !== 8'h80 || dir !== 1'b1 || wrap !== 1'b1 || step !== 1'b1) begin
      errors++;
      $display("FAIL right_wrap: led=%h dir=%b wrap=%b step=%b, expected led=80 dir=1 wrap=1 step=1", led, dir, wrap, step);
    end
    tick();
    checks++;
    if (wrap !== 1'b0 || step !== 1'b0 || led !== 8'h80) begin
      errors++;
      $display("FAIL right_pulse: led=%h wrap=%b step=%b, expected led=80 wrap=0 step=0", led, wrap, step);
    end
    bump();
    checks++;
    if (led !== 8'h40 || wrap !== 1'b0 || step !== 1'b1) begin
      errors++;
      $display("FAIL right_next: led=%h wrap=%b step=%b, expected led=40 wrap=0 step=1", led, wrap, step);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_led [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
    logic       exp_dir [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_wrp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    mode = 2'b10; bump(); tick();
    mode = 2'b01; bump(); tick();
    checks++;
    if (led !== 8'h40 || dir !== 1'b0) begin
      errors++; $display("FAIL bounce_setup: led=%h dir=%b, expected led=40 dir=0", led, dir);
    end
    mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      bump();
      checks++;
      if (led !== exp_led[i] || dir !== exp_dir[i] || wrap !== exp_wrp[i] || step !== 1'b1) begin
        errors++;
        $display("FAIL bounce[%0d]: led=%h dir=%b wrap=%b step=%b, expected led=%h dir=%b wrap=%b step=1",
                 i, led, dir, wrap, step, exp_led[i], exp_dir[i], exp_wrp[i]);
      end
      tick();
    end
  endtask

  task automatic test_pause_hold();
    pause = 1'b1; mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      bump();
      checks++;
      if (led !== 8'h10 || step !== 1'b0) begin
        errors++; $display("FAIL pause[%0d]: led=%h step=%b, expected led=10 step=0", i, led, step);
      end
    end
    pause = 1'b0; mode = 2'b00;
    for (int i = 0; i < 2; i++) begin
      bump();
      checks++;
      if (led !== 8'h10 || step !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: led=%h step=%b, expected led=10 step=0", i, led, step);
      end
    end
    mode = 2'b01;
    bump();
    checks++;
    if (led !== 8'h20 || step !== 1'b1) begin
      errors++; $display("FAIL resume_move: led=%h step=%b, expected led=20 step=1", led, step);
    end
    tick();
    checks++;
    if (led !== 8'h20 || step !== 1'b0) begin
      errors++; $display("FAIL resume_single: led=%h step=%b, expected led=20 step=0", led, step);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'b10; bump();
    checks++;
    if (led !== 8'h10) begin
      errors++; $display("FAIL rstmid_setup: led=%h expected 10", led);
    end
    rst = 1'b1; bump();
    checks++;
    if (led !== 8'h01 || step !== 1'b0 || dir !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL rstmid: led=%h step=%b dir=%b wrap=%b, expected led=01 step=0 dir=0 wrap=0", led, step, dir, wrap);
    end
    rst = 1'b0; tick();
    checks++;
    if (led !== 8'h01 || step !== 1'b0) begin
      errors++; $display("FAIL rstmid_release: led=%h step=%b, expected led=01 step=0", led, step);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 1) == 1) count_in = 4'($urandom);
      tick();
      checks++;
      if (led !== (LED_W'(1) << m_pos) || dir !== 1'(m_dir) || step !== 1'(m_step) || wrap !== 1'(m_wrap)) begin
        errors++;
        $display("FAIL random[%0d]: led=%h dir=%b step=%b wrap=%b, expected led=%h dir=%0d step=%0d wrap=%0d",
                 i, led, dir, step, wrap, LED_W'(1) << m_pos, m_dir, m_step, m_wrap);
      end
`ifdef LED_CHASER_STEP_CNT_EN
      checks++;
      if (step_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL random_step_cnt[%0d]: got %0d expected %0d", i, step_cnt, m_cnt);
      end
`endif
    end
    rst = 1'b0; pause = 1'b0;
  endtask

`ifdef LED_CHASER_STEP_CNT_EN
  task automatic test_step_cnt();
    rst = 1'b1; tick(); rst = 1'b0; mode = 2'b01; pause = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin bump(); tick(); end
    checks++;
    if (step_cnt !== 16'd5) begin
      errors++; $display("FAIL step_cnt_five: got %0d expected 5", step_cnt);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (step_cnt !== 16'd0) begin
      errors++; $display("FAIL step_cnt_clear: got %0d expected 0", step_cnt);
    end
    for (int i = 0; i < 65540; i++) bump();
    checks++;
    if (step_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL step_cnt_sat: got %h expected ffff", step_cnt);
    end
    for (int i = 0; i < 3; i++) bump();
    checks++;
    if (step_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL step_cnt_hold: got %h expected ffff", step_cnt);
    end
  endtask
`endif

  initial begin
    m_pos = START_POS; m_dir = 0; m_step = 0; m_wrap = 0; m_prev = 0;
`ifdef LED_CHASER_STEP_CNT_EN
    m_cnt = 0;
`endif
    rst = 1'b1; count_in = 4'd0; mode = 2'b00; pause = 1'b0;
    #1;
    test_reset();
    test_left();
    test_right();
    test_bounce();
    test_pause_hold();
    test_reset_mid();
    test_random();
`ifdef LED_CHASER_STEP_CNT_EN
    test_step_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
